// File: rtl/decoder_2to4.sv
// ----------------------------------------------------------------------------
// decoder_2to4
//
// Two-bit to one-hot decoder with a registered snapshot of the last enabled
// decode and optional per-code saturating occurrence counters.
//
// Build option:
//   DECODER_COUNT_EN  when defined, the four saturating counters are built;
//                     when undefined, count_00..count_11 are tied to zero
//                     and the ports remain present.
//
// Ports:
//   clk        system clock, rising-edge active
//   reset      synchronous active-high reset
//   en         sample enable for registered outputs and counters
//   val_in     2-bit code to decode
//   val_00..11 combinational one-hot flags, independent of clk/reset/en
//   onehot_q   registered decode of the last sampled code
//   valid_q    set once at least one sample has been taken since reset
//   count_*    CNT_W-bit saturating per-code sample counts
// ----------------------------------------------------------------------------
module decoder_2to4 #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       val_in,
    output logic             val_00,
    output logic             val_01,
    output logic             val_10,
    output logic             val_11,
    output logic [3:0]       onehot_q,
    output logic             valid_q,
    output logic [CNT_W-1:0] count_00,
    output logic [CNT_W-1:0] count_01,
    output logic [CNT_W-1:0] count_10,
    output logic [CNT_W-1:0] count_11
);

    logic [3:0] dec;
    logic [3:0] onehot_d;
    logic       valid_d;

    // Zero-latency decode; bit i corresponds to code i.
    always_comb begin
        dec = 4'b0001 << val_in;
    end

    assign val_00 = dec[0];
    assign val_01 = dec[1];
    assign val_10 = dec[2];
    assign val_11 = dec[3];

    always_comb begin
        onehot_d = onehot_q;
        valid_d  = valid_q;
        if (en) begin
            onehot_d = dec;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            onehot_q <= 4'b0000;
            valid_q  <= 1'b0;
        end else begin
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
        end
    end

`ifdef DECODER_COUNT_EN
    localparam logic [CNT_W-1:0] CntMax = '1;

    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    // Only the counter selected by the sampled code can move; a counter at
    // its maximum holds until reset instead of wrapping.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (en && dec[i] && (cnt_q[i] != CntMax)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset) begin
                cnt_q[i] <= '0;
            end else begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign count_00 = cnt_q[0];
    assign count_01 = cnt_q[1];
    assign count_10 = cnt_q[2];
    assign count_11 = cnt_q[3];
`else
    assign count_00 = '0;
    assign count_01 = '0;
    assign count_10 = '0;
    assign count_11 = '0;
`endif

`ifndef SYNTHESIS
    // Sampling an unknown code is illegal.
    a_known_code_when_enabled : assert property (
        @(posedge clk) disable iff (reset) en |-> !$isunknown(val_in)
    );
`endif

endmodule

// File: tb/tb_decoder_2to4.sv
// ----------------------------------------------------------------------------
// tb_decoder_2to4
//
// Self-checking bench for decoder_2to4. Two instances share all inputs: one
// with the default CNT_W=8 and one with CNT_W=2 to reach saturation quickly.
// Expected values come from constant tables and from a reference model that
// keeps plain integer counts clamped at 2^CNT_W-1. Honors DECODER_COUNT_EN.
// ----------------------------------------------------------------------------
module tb_decoder_2to4;

`ifdef DECODER_COUNT_EN
    localparam bit CountEn = 1'b1;
`else
    localparam bit CountEn = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] val_in;

    logic       a_v00, a_v01, a_v10, a_v11;
    logic [3:0] a_onehot;
    logic       a_valid;
    logic [7:0] a_c00, a_c01, a_c10, a_c11;

    logic       b_v00, b_v01, b_v10, b_v11;
    logic [3:0] b_onehot;
    logic       b_valid;
    logic [1:0] b_c00, b_c01, b_c10, b_c11;

    int checks;
    int failures;

    // Reference model state.
    int m_code;      // last sampled code, -1 when none
    int m_cnt [4];   // unbounded sample counts since reset

    decoder_2to4 #(.CNT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .val_in   (val_in),
        .val_00   (a_v00),
        .val_01   (a_v01),
        .val_10   (a_v10),
        .val_11   (a_v11),
        .onehot_q (a_onehot),
        .valid_q  (a_valid),
        .count_00 (a_c00),
        .count_01 (a_c01),
        .count_10 (a_c10),
        .count_11 (a_c11)
    );

    decoder_2to4 #(.CNT_W(2)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .val_in   (val_in),
        .val_00   (b_v00),
        .val_01   (b_v01),
        .val_10   (b_v10),
        .val_11   (b_v11),
        .onehot_q (b_onehot),
        .valid_q  (b_valid),
        .count_00 (b_c00),
        .count_01 (b_c01),
        .count_10 (b_c10),
        .count_11 (b_c11)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int exp_cnt(input int code, input int width);
        int lim;
        lim = (1 << width) - 1;
        if (!CountEn) return 0;
        return (m_cnt[code] > lim) ? lim : m_cnt[code];
    endfunction

    task automatic check_comb(input string tag);
        int exp_flags;
        exp_flags = 0;
        for (int i = 0; i < 4; i++) begin
            if (int'(val_in) == i) exp_flags = exp_flags | (8 >> i);
        end
        chk({tag, " flags"}, {a_v00, a_v01, a_v10, a_v11}, exp_flags);
        chk({tag, " flags w2"}, {b_v00, b_v01, b_v10, b_v11}, exp_flags);
    endtask

    task automatic check_regs(input string tag);
        int exp_oh;
        exp_oh = (m_code < 0) ? 0 : (1 << m_code);
        chk({tag, " onehot_q"}, a_onehot, exp_oh);
        chk({tag, " valid_q"}, a_valid, (m_code < 0) ? 0 : 1);
        chk({tag, " onehot_q w2"}, b_onehot, exp_oh);
        chk({tag, " valid_q w2"}, b_valid, (m_code < 0) ? 0 : 1);
        chk({tag, " count_00"}, a_c00, exp_cnt(0, 8));
        chk({tag, " count_01"}, a_c01, exp_cnt(1, 8));
        chk({tag, " count_10"}, a_c10, exp_cnt(2, 8));
        chk({tag, " count_11"}, a_c11, exp_cnt(3, 8));
        chk({tag, " count_00 w2"}, b_c00, exp_cnt(0, 2));
        chk({tag, " count_01 w2"}, b_c01, exp_cnt(1, 2));
        chk({tag, " count_10 w2"}, b_c10, exp_cnt(2, 2));
        chk({tag, " count_11 w2"}, b_c11, exp_cnt(3, 2));
        check_comb(tag);
    endtask

    // Drive inputs after a falling edge, clock once, update the model, and
    // compare on the next falling edge.
    task automatic step(input logic r, input logic e, input logic [1:0] v, input string tag);
        reset  = r;
        en     = e;
        val_in = v;
        @(posedge clk);
        if (r) begin
            m_code = -1;
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        end else if (e) begin
            m_code = int'(v);
            m_cnt[v] = m_cnt[v] + 1;
        end
        @(negedge clk);
        check_regs(tag);
    endtask

    typedef struct {
        logic [1:0] v;
        logic [3:0] flags;   // {val_00, val_01, val_10, val_11}
    } comb_vec_t;

    typedef struct {
        logic [1:0] v;
        logic [3:0] onehot;
    } seq_vec_t;

    comb_vec_t comb_tbl [4];
    seq_vec_t  seq_tbl  [4];
    int        sat_tbl  [6];

    initial begin
        checks   = 0;
        failures = 0;
        m_code   = -1;
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;

        comb_tbl[0] = '{v: 2'b00, flags: 4'b1000};
        comb_tbl[1] = '{v: 2'b01, flags: 4'b0100};
        comb_tbl[2] = '{v: 2'b10, flags: 4'b0010};
        comb_tbl[3] = '{v: 2'b11, flags: 4'b0001};

        seq_tbl[0] = '{v: 2'b00, onehot: 4'b0001};
        seq_tbl[1] = '{v: 2'b01, onehot: 4'b0010};
        seq_tbl[2] = '{v: 2'b01, onehot: 4'b0010};
        seq_tbl[3] = '{v: 2'b11, onehot: 4'b1000};

        sat_tbl = '{1, 2, 3, 3, 3, 3};

        reset  = 1'b1;
        en     = 1'b0;
        val_in = 2'b00;

        // Reset for two cycles, then idle with en=0.
        step(1'b1, 1'b0, 2'b10, "reset0");
        step(1'b1, 1'b0, 2'b10, "reset1");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b10, "idle_en0");

        // Combinational sweep between edges: four 1-unit steps inside a
        // half period, with en=0 so the edges that follow are inert anyway.
        for (int i = 0; i < 4; i++) begin
            #1;
            val_in = comb_tbl[i].v;
            #0;
            chk("comb_tbl", {a_v00, a_v01, a_v10, a_v11}, int'(comb_tbl[i].flags));
        end
        @(negedge clk);

        // Consecutive enabled samples.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, seq_tbl[i].v, "seq");
            chk("seq_tbl onehot_q", a_onehot, int'(seq_tbl[i].onehot));
        end
        chk("seq final count_00", a_c00, CountEn ? 1 : 0);
        chk("seq final count_01", a_c01, CountEn ? 2 : 0);
        chk("seq final count_10", a_c10, 0);
        chk("seq final count_11", a_c11, CountEn ? 1 : 0);

        // Reset together with en=1 discards that sample.
        step(1'b1, 1'b1, 2'b11, "reset_with_en");
        chk("reset_with_en onehot_q", a_onehot, 0);
        chk("reset_with_en count_01", a_c01, 0);

        // Saturation on the 2-bit instance.
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 2'b10, "sat");
            chk("sat_tbl count_10 w2", b_c10, CountEn ? sat_tbl[i] : 0);
            chk("sat count_10 w8", a_c10, CountEn ? i + 1 : 0);
        end
        // Saturated counter holds across disabled and enabled cycles.
        step(1'b0, 1'b0, 2'b01, "sat_hold_en0");
        step(1'b0, 1'b1, 2'b10, "sat_hold");
        chk("sat_hold count_10 w2", b_c10, CountEn ? 3 : 0);

        // Mid-stream reset then first enabled edge samples normally.
        step(1'b1, 1'b1, 2'b10, "mid_reset");
        step(1'b0, 1'b1, 2'b01, "post_reset");

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic r;
            logic e;
            logic [1:0] v;
            r = ($urandom_range(0, 31) == 0);
            e = ($urandom_range(0, 3) != 0);
            v = 2'($urandom_range(0, 3));
            step(r, e, v, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
